// File: rtl/conv_ilv_pkg.sv
// Shared constants and delay-line geometry helpers for the convolutional interleaver.
package conv_ilv_pkg;

    localparam logic [7:0] SYNC_A_DEFAULT = 8'h47;
    localparam logic [7:0] SYNC_B_DEFAULT = 8'hB8;

    function automatic int unsigned branch_len(input int unsigned k, input int unsigned b,
                                               input int unsigned m, input int unsigned mode);
        return (mode != 0) ? (b - 1 - k) * m : k * m;
    endfunction

    function automatic int unsigned branch_base(input int unsigned k, input int unsigned b,
                                                input int unsigned m, input int unsigned mode);
        int unsigned sum;
        sum = 0;
        for (int unsigned j = 0; j < k; j++) sum += branch_len(j, b, m, mode);
        return sum;
    endfunction

    function automatic int unsigned total_depth(input int unsigned b, input int unsigned m);
        return m * b * (b - 1) / 2;
    endfunction

endpackage

// File: rtl/conv_ilv_ram.sv
// Single-port delay-line storage: combinational read at the write address, write on clk.
module conv_ilv_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1122,
    parameter int unsigned AW    = 11
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/conv_interleaver.sv
// Parametrised convolutional interleaver/deinterleaver with sync-word commutator realignment.
module conv_interleaver
    import conv_ilv_pkg::*;
#(
    parameter int unsigned       WIDTH      = 8,
    parameter int unsigned       BRANCHES   = 12,
    parameter int unsigned       DEPTH_INC  = 17,
    parameter int unsigned       MODE       = 0,
    parameter bit                SYNC_ALIGN = 1'b1,
    parameter logic [WIDTH-1:0]  SYNC_A     = WIDTH'(SYNC_A_DEFAULT),
    parameter logic [WIDTH-1:0]  SYNC_B     = WIDTH'(SYNC_B_DEFAULT),
    parameter logic [WIDTH-1:0]  FILL       = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        di_rdy,
    output logic                        di_acpt,
    input  logic [WIDTH-1:0]            di_data,
    output logic                        do_rdy,
    input  logic                        do_acpt,
    output logic [WIDTH-1:0]            do_data,
    output logic [$clog2(BRANCHES)-1:0] do_branch,
    output logic                        do_filled,
    output logic                        sync_slip,
    output logic [15:0]                 slip_count
);

    localparam int unsigned DEPTH   = total_depth(BRANCHES, DEPTH_INC);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(BRANCHES);
    localparam int unsigned ROT_MAX = (BRANCHES - 1) * DEPTH_INC;
    localparam int unsigned RW      = $clog2(ROT_MAX + 1);

    logic [CW-1:0]    r_cmt;
    logic [RW-1:0]    r_rot;
    logic [AW-1:0]    r_ptr [BRANCHES];
    logic             r_do_rdy;
    logic [WIDTH-1:0] r_do_data;
    logic [CW-1:0]    r_do_branch;
    logic             r_do_filled;
    logic             r_slip;
    logic [15:0]      r_slip_cnt;

    logic [RW-1:0]    w_len_tab  [BRANCHES];
    logic [AW-1:0]    w_base_tab [BRANCHES];
    logic             w_xfer, w_sync, w_wrap, w_we, w_filled, w_ptr_wrap;
    logic [CW-1:0]    w_br, w_cmt_nxt;
    logic [RW-1:0]    w_len;
    logic [AW-1:0]    w_ptr, w_addr;
    logic [WIDTH-1:0] w_rdata, w_out;

    for (genvar k = 0; k < BRANCHES; k++) begin : g_tab
        assign w_len_tab[k]  = RW'(branch_len(k, BRANCHES, DEPTH_INC, MODE));
        assign w_base_tab[k] = AW'(branch_base(k, BRANCHES, DEPTH_INC, MODE));
    end

    assign di_acpt = reset_n & enable & (~r_do_rdy | do_acpt);
    assign w_xfer  = di_rdy & di_acpt;

    // A sync word off branch 0 is forced onto branch 0; pointers and rot stay untouched.
    assign w_sync    = SYNC_ALIGN && ((di_data == SYNC_A) || (di_data == SYNC_B)) && (r_cmt != '0);
    assign w_br      = w_sync ? '0 : r_cmt;
    assign w_wrap    = !w_sync && (r_cmt == CW'(BRANCHES - 1));
    assign w_cmt_nxt = w_sync ? CW'(1) : (w_wrap ? '0 : r_cmt + 1'b1);

    assign w_len      = w_len_tab[w_br];
    assign w_ptr      = r_ptr[w_br];
    assign w_addr     = w_base_tab[w_br] + w_ptr;
    assign w_we       = w_xfer && (w_len != '0);
    assign w_ptr_wrap = (32'(w_ptr) + 32'd1) == 32'(w_len);

    // Storage is never cleared, so unwritten slots are masked purely by the rotation count.
    assign w_filled = (r_rot >= w_len);
    assign w_out    = (w_len == '0) ? di_data : (w_filled ? w_rdata : FILL);

    conv_ilv_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (di_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmt       <= '0;
            r_rot       <= '0;
            for (int unsigned k = 0; k < BRANCHES; k++) r_ptr[k] <= '0;
            r_do_rdy    <= 1'b0;
            r_do_data   <= '0;
            r_do_branch <= '0;
            r_do_filled <= 1'b0;
            r_slip      <= 1'b0;
            r_slip_cnt  <= '0;
        end else begin
            if (w_xfer) begin
                r_cmt       <= w_cmt_nxt;
                if (w_wrap && (r_rot != RW'(ROT_MAX))) r_rot <= r_rot + 1'b1;
                if (w_we) r_ptr[w_br] <= w_ptr_wrap ? '0 : w_ptr + 1'b1;
                r_do_data   <= w_out;
                r_do_branch <= w_br;
                r_do_filled <= w_filled;
            end
            r_do_rdy <= w_xfer | (r_do_rdy & ~do_acpt);
            r_slip   <= w_xfer & w_sync;
            if (w_xfer && w_sync && (r_slip_cnt != '1)) r_slip_cnt <= r_slip_cnt + 1'b1;
        end
    end

    assign do_rdy     = r_do_rdy;
    assign do_data    = r_do_data;
    assign do_branch  = r_do_branch;
    assign do_filled  = r_do_filled;
    assign sync_slip  = r_slip;
    assign slip_count = r_slip_cnt;

endmodule
